// File: rtl/gray_input_debouncer_pkg.sv
// Shared definitions for the switch-input conditioning stage of the Gray decoder.
// Holds the debouncer state encoding and the default hold-window width.
package gray_input_debouncer_pkg;

    localparam int DEBOUNCE_W_DEFAULT = 6;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_e;

endpackage

// File: rtl/gray_input_debouncer_sync_2ff.sv
// Parameterized-width two-flop synchronizer for asynchronous switch lines.
// Both stages reset to 0.
module sync_2ff
    import gray_input_debouncer_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk_pi,
    input  logic         rst_pi,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gray_input_debouncer.sv
// Synchronizes and debounces the raw switch bus, then presents a stable Gray code
// with a one-cycle valid strobe and a flag for commits that are not a single-bit step.
module gray_input_debouncer
    import gray_input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_W = DEBOUNCE_W_DEFAULT,
    parameter int CODE_W     = 4
) (
    input  logic              clk_pi,
    input  logic              rst_pi,
    input  logic [CODE_W-1:0] sw_pi,
    output logic [CODE_W-1:0] codigo_gray_po,
    output logic              valid_po,
    output logic              gray_err_po
);

    localparam logic [DEBOUNCE_W-1:0] CNT_MAX = '1;

    logic [CODE_W-1:0]     sample;
    state_e                state_q, state_d;
    logic [CODE_W-1:0]     cand_q, cand_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic [CODE_W-1:0]     code_q, code_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    // True when the two codes are exactly one bit apart (a legal Gray step).
    function automatic logic is_gray_step(input logic [CODE_W-1:0] a,
                                          input logic [CODE_W-1:0] b);
        return $countones(a ^ b) == 1;
    endfunction

    sync_2ff #(.W(CODE_W)) u_sync (
        .clk_pi (clk_pi),
        .rst_pi (rst_pi),
        .d_i    (sw_pi),
        .q_o    (sample)
    );

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (sample != code_q) begin
                    cand_d  = sample;
                    cnt_d   = '0;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                // Bounce back to the committed code wins over everything else.
                if (sample == code_q) begin
                    state_d = ST_STABLE;
                end else if (sample != cand_q) begin
                    cand_d = sample;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    code_d  = cand_q;
                    valid_d = 1'b1;
                    err_d   = !is_gray_step(cand_q, code_q);
                    state_d = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            state_q <= ST_STABLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign codigo_gray_po = code_q;
    assign valid_po       = valid_q;
    assign gray_err_po    = err_q;

endmodule

// File: doc/gray_input_debouncer.md
# gray_input_debouncer

Upstream conditioning stage for the Gray-code decoder top. It takes the four raw slide-switch lines and passes them through a two-flop synchronizer and a counter-based bus debouncer. It presents a stable 4-bit Gray code plus a one-cycle `valid_po` strobe to the decoder. It also flags any committed transition that is not a single-bit Gray step, such as a multi-switch flip or a skipped code.

## Interface
- `DEBOUNCE_W`, default 6: debounce counter width. A candidate must hold for 2^DEBOUNCE_W consecutive cycles.
- `CODE_W`, default 4: switch bus width.

Ports:
- `clk_pi`, in, 1: single system clock.
- `rst_pi`, in, 1: reset, asynchronous, active-high.
- `sw_pi`, in, CODE_W: raw, asynchronous, bouncing switch inputs.
- `codigo_gray_po`, out, CODE_W: debounced Gray code, registered.
- `valid_po`, out, 1: one-cycle pulse when `codigo_gray_po` takes a new value.
- `gray_err_po`, out, 1: one-cycle pulse, coincident with `valid_po`, when the new and old codes differ in more than one bit.

## Operation
- Synchronizer: two flops per bit, reset to 0. `sample` is the second-stage output.
- The FSM has two states: STABLE and COUNT. It uses a candidate register `cand` (CODE_W bits) and a counter `cnt` (DEBOUNCE_W bits).
- STABLE:
  - If `sample != codigo_gray_po`, then `cand <= sample`, `cnt <= 0`, and the FSM goes to COUNT.
  - Otherwise it holds.
- COUNT, with priority in the order listed:
  1. If `sample == codigo_gray_po` (bounced back to the old code), go to STABLE. No strobe.
  2. Else if `sample != cand`, then `cand <= sample` and `cnt <= 0`. Stay in COUNT (restart).
  3. Else if `cnt == 2^DEBOUNCE_W - 1`, commit: `codigo_gray_po <= cand`, `valid_po <= 1`, and `gray_err_po <= (popcount(cand ^ codigo_gray_po) != 1)`. Go to STABLE.
  4. Else `cnt <= cnt + 1`.
- `cnt` never wraps. Commit occurs exactly at all-ones.
- `valid_po` and `gray_err_po` are 0 in every cycle other than the one following a commit edge.
- A commit of identical code is impossible: rule 1 takes precedence.

## Timing
- Reset values (asynchronous, immediate):
  - Sync flops = 0, `cand` = 0, `cnt` = 0, state = STABLE.
  - `codigo_gray_po` = 0, `valid_po` = 0, `gray_err_po` = 0.
- Reset asserted mid-COUNT aborts the pending change. No strobe is issued after release.
- After release, a nonzero `sw_pi` is treated as a change from 0. It commits normally, with `gray_err_po` evaluated against 0.
- Latency, when `sw_pi` changes cleanly and is first captured at clock edge k:
  - `sample` updates at edge k+1.
  - The FSM enters COUNT at edge k+2.
  - The commit edge is k+2+2^DEBOUNCE_W, and `valid_po` is high for the following cycle.
  - With the default of 6, that is 66 cycles.
- Any bounce resets the hold window to a full 2^DEBOUNCE_W cycles from the last change of `sample`.
- Outputs are registered only. There is no combinational path from `sw_pi`.

## Structure
- The shared project package/header holds:
  - the state encodings, localparams `ST_STABLE = 1'b0` and `ST_COUNT = 1'b1`;
  - the default `DEBOUNCE_W`.
- Sub-module `sync_2ff`: parameterized-width two-flop synchronizer, with the same clock and reset. It is instantiated once for the `sw_pi` bus.
- Popcount/adjacency check: a local function inside `gray_input_debouncer`. No separate module.

## Test plan
All directed tests run with `DEBOUNCE_W = 3` (8-cycle hold, commit edge at k+10) and a 20 ns clock.

- **Reset:** hold `rst_pi = 1` with `sw_pi = 4'b1010`.
  - Required: `codigo_gray_po = 0` and `valid_po = gray_err_po = 0` throughout.
  - After release, 1010 commits at edge k+10 with `gray_err_po = 1`.
- **Clean Gray walk:** step 0000→0001→0011→0010→0110, holding each for 20 cycles.
  - Required: each commit 10 edges after the change.
  - `valid_po` is exactly 1 cycle wide, and `gray_err_po = 0` every time.
- **Bounce:** from 0001, toggle `sw_pi` between 0011 and 0001 every 3 cycles for 15 cycles, then hold 0011.
  - Required: no `valid_po` during the toggling.
  - A single commit to 0011 occurs 10 edges after the final change.
- **Bounce-back:** from 0011, apply 0010 for 4 cycles, then return to 0011.
  - Required: no `valid_po`, the output stays 0011, and the FSM returns to STABLE.
- **Non-Gray jump:** from 0000, apply 0101 and hold.
  - Required: a commit to 0101 with `valid_po = 1` and `gray_err_po = 1` in the same cycle.
- **Reset mid-count:** from 0000, apply 1000. Pulse `rst_pi` for 1 cycle, 5 cycles later.
  - Required: no strobe from the aborted window.
  - A fresh commit to 1000 occurs 10 edges after the first post-reset capture edge.
